// File: rtl/reset_tick_gen.sv
// Reset sequencer and tick generator for the clk50 domain: power-on hold plus stretched
// merge of async reset requests, and programmable one-cycle clock enables.
module reset_tick_gen #(
  parameter int                NSRC           = 2,
  parameter logic [NSRC-1:0]   SRC_ACT_HIGH   = NSRC'(2'b01),
  parameter int                POR_CYCLES     = 8,
  parameter int                STRETCH_CYCLES = 31,
  parameter int                NTICK          = 2,
  parameter int                DIV_W          = 27
) (
  input  logic                   clk50,
  input  logic                   reset,
  input  logic [NSRC-1:0]        rst_src,
  input  logic [NSRC-1:0]        src_mask,
  input  logic [NTICK*DIV_W-1:0] div_val,
  input  logic [NTICK-1:0]       tick_en,
  output logic                   chip_reset,
  output logic                   chip_reset_n,
  output logic [NSRC-1:0]        reset_cause,
  output logic                   por_flag,
  output logic [NTICK-1:0]       tick,
  output logic [NTICK-1:0]       tick_sq
);

  localparam int CNT_MAX   = (POR_CYCLES > STRETCH_CYCLES) ? POR_CYCLES : STRETCH_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int POR_LD_I  = (POR_CYCLES > 0) ? POR_CYCLES - 1 : 0;
  localparam int STR_LD_I  = (STRETCH_CYCLES > 0) ? STRETCH_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] POR_LOAD     = POR_LD_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] STRETCH_LOAD = STR_LD_I[CNT_W-1:0];

  typedef enum logic [1:0] {
    S_POR     = 2'd0,
    S_HOLD    = 2'd1,
    S_STRETCH = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  logic [NSRC-1:0]  r_sync1;
  logic [NSRC-1:0]  r_sync2;
  logic [NSRC-1:0]  w_req;
  logic             w_any_req;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_chip_reset;
  logic             r_chip_reset_n;
  logic [NSRC-1:0]  r_cause;
  logic             r_por_flag;

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= rst_src;
      r_sync2 <= r_sync1;
    end
  end

  // XNOR with the polarity mask turns every source into an active-high request.
  assign w_req     = ~(r_sync2 ^ SRC_ACT_HIGH) & src_mask;
  assign w_any_req = |w_req;

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_state        <= S_POR;
      r_cnt          <= POR_LOAD;
      r_chip_reset   <= 1'b1;
      r_chip_reset_n <= 1'b0;
      r_cause        <= '0;
      r_por_flag     <= 1'b1;
    end else begin
      case (r_state)
        S_POR: begin
          if (r_cnt == '0) begin
            if (w_any_req) begin
              r_state <= S_HOLD;
              r_cause <= w_req;
            end else begin
              r_state        <= S_RUN;
              r_chip_reset   <= 1'b0;
              r_chip_reset_n <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_RUN: begin
          if (w_any_req) begin
            r_state        <= S_HOLD;
            r_chip_reset   <= 1'b1;
            r_chip_reset_n <= 1'b0;
            r_por_flag     <= 1'b0;
            r_cause        <= w_req;
          end
        end

        S_HOLD: begin
          r_cause <= r_cause | w_req;
          if (!w_any_req) begin
            if (STRETCH_CYCLES == 0) begin
              r_state        <= S_RUN;
              r_chip_reset   <= 1'b0;
              r_chip_reset_n <= 1'b1;
            end else begin
              r_state <= S_STRETCH;
              r_cnt   <= STRETCH_LOAD;
            end
          end
        end

        S_STRETCH: begin
          // A fresh request restarts the stretch from HOLD and keeps accumulating cause.
          if (w_any_req) begin
            r_state <= S_HOLD;
            r_cause <= r_cause | w_req;
          end else if (r_cnt == '0) begin
            r_state        <= S_RUN;
            r_chip_reset   <= 1'b0;
            r_chip_reset_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state        <= S_POR;
          r_cnt          <= POR_LOAD;
          r_chip_reset   <= 1'b1;
          r_chip_reset_n <= 1'b0;
        end
      endcase
    end
  end

  assign chip_reset   = r_chip_reset;
  assign chip_reset_n = r_chip_reset_n;
  assign reset_cause  = r_cause;
  assign por_flag     = r_por_flag;

  for (genvar k = 0; k < NTICK; k++) begin : g_tick
    logic [DIV_W-1:0] w_div;
    logic [DIV_W-1:0] r_dc;
    logic             r_tick;
    logic             r_tick_sq;

    assign w_div = div_val[k*DIV_W +: DIV_W];

    // The >= compare means a divisor lowered below the running count ticks at once.
    always_ff @(posedge clk50) begin
      if (reset) begin
        r_dc      <= '0;
        r_tick    <= 1'b0;
        r_tick_sq <= 1'b0;
      end else if (r_chip_reset || !tick_en[k]) begin
        r_dc   <= '0;
        r_tick <= 1'b0;
      end else if (r_dc >= w_div) begin
        r_dc      <= '0;
        r_tick    <= 1'b1;
        r_tick_sq <= ~r_tick_sq;
      end else begin
        r_dc   <= r_dc + DIV_W'(1);
        r_tick <= 1'b0;
      end
    end

    assign tick[k]    = r_tick;
    assign tick_sq[k] = r_tick_sq;
  end

endmodule

// File: doc/reset_tick_gen.md
Name: reset_tick_gen

Overview:
Parametrised reset sequencer and clock-enable generator for the clk50 domain of the AY-3-8500 core.
- Merges NSRC asynchronous reset requests (key, host, spare) into one stretched, glitch-free chip reset, after a power-on hold.
- Generates NTICK programmable one-cycle tick enables plus square-wave companions, replacing free-running divided clocks.
- All outputs are synchronous to clk50; no derived clocks leave the block.

Parameters:
NSRC, 2, number of reset request sources
SRC_ACT_HIGH, 2'b01, per-source polarity; bit=1 active-high, bit=0 active-low
POR_CYCLES, 8, cycles chip_reset is held after reset deasserts
STRETCH_CYCLES, 31, cycles chip_reset is held after the last request releases
NTICK, 2, number of tick channels
DIV_W, 27, width of each divisor

Ports:
clk50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high; clock clk50
rst_src  in  NSRC  raw asynchronous reset requests
src_mask  in  NSRC  1=source enabled; masked sources are ignored after the synchroniser
div_val  in  NTICK*DIV_W  per-channel divisor; channel k at bits [k*DIV_W +: DIV_W]
tick_en  in  NTICK  per-channel enable
chip_reset  out  1  active-high core reset
chip_reset_n  out  1  inverse of chip_reset
reset_cause  out  NSRC  sources seen during the last HOLD episode
por_flag  out  1  1 when the last reset episode came from reset
tick  out  NTICK  one-cycle enable pulses
tick_sq  out  NTICK  toggles on every tick (50% duty square wave)

Behaviour:
- Synchronisers: each rst_src bit uses a 2-FF synchroniser, then polarity normalisation (req = SRC_ACT_HIGH[i] ? s : ~s), then AND with src_mask. any_req = OR of req.
- FSM states: POR, HOLD, STRETCH, RUN. Single down-counter cnt, wide enough for max(POR_CYCLES, STRETCH_CYCLES).
- While reset=1:
  - state=POR, cnt=POR_CYCLES-1, chip_reset=1, chip_reset_n=0.
  - reset_cause=0, por_flag=1.
  - All tick=0, tick_sq=0, divider counters=0, synchroniser FFs=0.
- POR: cnt decrements each cycle. At cnt==0, go to HOLD if any_req, otherwise RUN. The POR hold lasts exactly POR_CYCLES cycles after reset falls.
- RUN: chip_reset=0. When any_req=1, go to HOLD; chip_reset rises the next cycle (rst_src edge to chip_reset = 3 clk50 edges).
  - On the RUN->HOLD transition: por_flag<=0, reset_cause<=req.
- HOLD: chip_reset=1. reset_cause |= req each cycle. When any_req=0, go to STRETCH with cnt=STRETCH_CYCLES-1.
- STRETCH: chip_reset=1, cnt decrements.
  - any_req=1 returns to HOLD (restarts the stretch; cause accumulates).
  - At cnt==0 with no request, go to RUN. chip_reset stays high for exactly STRETCH_CYCLES cycles after the last synchronised request.
- STRETCH_CYCLES=0: HOLD goes directly to RUN.
- A request pulse shorter than one clk50 period may be missed. This is not guaranteed to be caught.
- Tick channel k (divider counter dc_k, DIV_W bits):
  - If chip_reset=1 or tick_en[k]=0: dc_k<=0 and tick[k]<=0. tick_sq[k] holds (cleared only by reset).
  - Else if dc_k >= div_val_k: dc_k<=0, tick[k]<=1, tick_sq[k] toggles. Otherwise dc_k increments and tick[k]<=0.
  - Tick period is div_val_k+1 cycles. div_val_k=0 gives tick[k] held at 1.
  - div_val is sampled live. Lowering it below dc_k gives a tick on the next cycle (the >= compare). No wrap-around is possible.
  - First tick after enable or release occurs div_val_k+1 cycles later.
- All outputs are registered.

Test Plan:
- Power-on: reset high 4 cycles then low, no requests -> chip_reset high for exactly 8 cycles after reset falls; por_flag=1, reset_cause=0.
- Key request: rst_src[0]=1 for 10 cycles in RUN -> chip_reset rises 3 edges after assertion and falls 31 cycles after the synchronised release; reset_cause=2'b01, por_flag=0.
- Active-low host plus re-trigger: rst_src[1] low 5 cycles, released, then low again at stretch cycle 20 -> stretch restarts; total high time matches; reset_cause=2'b10.
- Masking and simultaneous sources: src_mask=2'b01, both sources asserted -> reset_cause=2'b01. Then src_mask=2'b11 -> reset_cause=2'b11.
- Ticks: div_val0=4, div_val1=0, tick_en=2'b11 -> tick[0] every 5th cycle with tick_sq[0] period 10; tick[1] constantly 1. Changing div_val0 4->1 while dc=3 -> tick on the next cycle.
- Reset mid-operation: assert reset during STRETCH with ticks running -> all outputs go to reset values on the next edge; POR sequence repeats.
